// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   ALU_WIDTH  - default operand width (the result is 2*ALU_WIDTH bits)
//   OP_*       - 4-bit opcode values (13-15 are reserved)
//   state_t    - control FSM state encoding
//   result_t   - {HI, LO} result word
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SHRA = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [2*ALU_WIDTH-1:0] result_t;

endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: shared iterative engine for signed MUL (radix-2 Booth) and
// signed DIV (non-restoring on magnitudes), one step per enabled cycle.
// Ports:
//   clock, clear  - clock and synchronous active-high reset
//   load          - capture operands and start a new operation
//   is_div        - with load: 1 = divide, 0 = multiply
//   step          - perform one iteration
//   a, b          - operands (multiplicand/dividend, multiplier/divisor)
//   last          - the current step is the final one
//   result        - value produced by the current step; on the last step
//                   it is the finished {HI, LO} answer (sign-corrected for DIV)
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic               is_div,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // One extra accumulator bit keeps Booth add/sub and the non-restoring
  // partial remainder free of overflow, including for -2^(WIDTH-1).
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] m;
  logic             div_mode;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sum;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign last  = (count == '0);

  always_comb begin
    // Booth: examine {q[0], q_m1}, add/sub multiplicand, arithmetic shift.
    m_ext = {m[WIDTH-1], m};
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q[WIDTH-1:1]};

    // Non-restoring: sign of the partial remainder picks add or subtract.
    div_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_sum   = acc[WIDTH] ? div_shift + {1'b0, m} : div_shift - {1'b0, m};
    div_q     = {q[WIDTH-2:0], ~div_sum[WIDTH]};

    // Final correction: restore a negative remainder, then apply signs
    // (quotient toward zero, remainder follows the dividend).
    rem     = div_sum[WIDTH] ? div_sum[WIDTH-1:0] + m : div_sum[WIDTH-1:0];
    q_final = neg_q ? -div_q : div_q;
    r_final = neg_r ? -rem : rem;

    result = div_mode ? {r_final, q_final} : {booth_acc[WIDTH-1:0], booth_q};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
    end else if (load) begin
      acc      <= '0;
      q_m1     <= 1'b0;
      div_mode <= is_div;
      q        <= is_div ? a_mag : b;
      m        <= is_div ? b_mag : a;
      neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r    <= a[WIDTH-1];
      count    <= CW'(WIDTH - 1);
    end else if (step) begin
      if (div_mode) begin
        acc <= div_sum;
        q   <= div_q;
      end else begin
        acc  <= booth_acc;
        q    <= booth_q;
        q_m1 <= q[0];
      end
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU. One operation in flight; logic,
// add-class, shift, rotate and reserved ops answer in one cycle, MUL/DIV
// iterate WIDTH cycles in mul_div_iter.
// Ports:
//   clock, clear           - clock and synchronous active-high reset
//   req_valid / req_ready  - request handshake (ready only in IDLE)
//   opcode, input_a/b      - operation and operands, captured on acceptance
//   rsp_valid / rsp_ready  - response handshake
//   ALU_result             - registered {HI, LO}
//   div_by_zero            - qualifies the response: DIV with B == 0
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   input_a,
  input  logic [WIDTH-1:0]   input_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] ALU_result,
  output logic               div_by_zero
);

  localparam int SW = $clog2(WIDTH);

  state_t state;
  state_t state_next;

  logic               accept;
  logic               op_mul;
  logic               op_div;
  logic               div_zero;
  logic               start_iter;
  logic               iter_last;
  logic [2*WIDTH-1:0] iter_result;
  logic [WIDTH-1:0]   lo;
  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;

  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_valid && req_ready;
  assign op_mul     = (opcode == OP_MUL);
  assign op_div     = (opcode == OP_DIV);
  assign div_zero   = op_div && (input_b == '0);
  assign start_iter = accept && (op_mul || (op_div && !div_zero));

  mul_div_iter #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .clear  (clear),
    .load   (start_iter),
    .is_div (op_div),
    .step   ((state == ST_MUL) || (state == ST_DIV)),
    .a      (input_a),
    .b      (input_b),
    .last   (iter_last),
    .result (iter_result)
  );

  // Single-cycle ops. Rotates shift a doubled copy of A so a count of 0
  // falls out naturally as A unchanged.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    lo    = '0;
    sh    = input_b[SW-1:0];
    dbl   = {input_a, input_a};
    rol_w = dbl << sh;
    ror_w = dbl >> sh;
    case (opcode)
      OP_OR:   lo = input_a | input_b;
      OP_AND:  lo = input_a & input_b;
      OP_NOT:  lo = ~input_a;
      OP_ADD:  lo = input_a + input_b;
      OP_SUB:  lo = input_a - input_b;
      OP_NEG:  lo = -input_a;
      OP_SHL:  lo = input_a << sh;
      OP_SHR:  lo = input_a >> sh;
      OP_SHRA: lo = $signed(input_a) >>> sh;
      OP_ROL:  lo = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  lo = ror_w[WIDTH-1:0];
      default: lo = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_mul)                 state_next = ST_MUL;
          else if (op_div && !div_zero) state_next = ST_DIV;
          else                        state_next = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (iter_last) state_next = ST_DONE;
      ST_DONE:        if (rsp_ready) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // NOTE: clear is sampled on the clock edge only, so it dominates every
  // state and discards a pending result in a single cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= ST_IDLE;
      rsp_valid   <= 1'b0;
      ALU_result  <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (accept && !start_iter) begin
            rsp_valid   <= 1'b1;
            ALU_result  <= div_zero ? {input_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, lo};
            div_by_zero <= div_zero;
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_last) begin
            rsp_valid   <= 1'b1;
            ALU_result  <= iter_result;
            div_by_zero <= 1'b0;
          end
        end
        ST_DONE: if (rsp_ready) rsp_valid <= 1'b0;
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  opcode = '0;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] ALU_result;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .opcode      (opcode),
    .input_a     (input_a),
    .input_b     (input_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .ALU_result  (ALU_result),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [63:0] res, logic dbz);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.dbz = dbz;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: direct arithmetic on the operation's definition.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output result_t r,
                                output logic z);
    logic [31:0]        lo;
    logic signed [31:0] as_;
    longint             sa, sb, qq, rr, p;
    int                 s;
    s   = int'(b[4:0]);
    as_ = a;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lo  = '0;
    z   = 1'b0;
    r   = '0;
    case (op)
      4'd0:  lo = a | b;
      4'd1:  lo = a & b;
      4'd2:  lo = ~a;
      4'd3:  lo = a + b;
      4'd4:  lo = a - b;
      4'd5:  lo = 32'd0 - a;
      4'd8:  lo = a << s;
      4'd9:  lo = a >> s;
      4'd10: lo = as_ >>> s;
      4'd11: begin lo = a; for (int i = 0; i < s; i++) lo = {lo[30:0], lo[31]}; end
      4'd12: begin lo = a; for (int i = 0; i < s; i++) lo = {lo[0], lo[31:1]}; end
      default: lo = '0;
    endcase
    r = {32'd0, lo};
    if (op == 4'd6) begin
      p = sa * sb;
      r = p;
    end else if (op == 4'd7) begin
      if (b == 0) begin
        r = {a, 32'hFFFF_FFFF};
        z = 1'b1;
      end else begin
        qq = sa / sb;
        rr = sa % sb;
        r  = {rr[31:0], qq[31:0]};
      end
    end
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!req_ready && w < 100) begin tick(); w++; end
    check("req_ready before issue", req_ready, 1);
    opcode = op; input_a = a; input_b = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    opcode  = 4'($urandom);
    input_a = $urandom;
    input_b = $urandom;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] er, input logic ez);
    int lat;
    int exp_lat;
    exp_lat = ((op == 4'd6) || (op == 4'd7 && b != 0)) ? 33 : 1;
    rsp_ready = 1'b1;
    issue(op, a, b);
    lat = 1;
    while (!rsp_valid && lat < 100) begin tick(); lat++; end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, ALU_result, er);
    check({tag, " div_by_zero"}, {63'd0, div_by_zero}, {63'd0, ez});
    tick();
    check({tag, " after handshake {rsp_valid,req_ready}"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    result_t     er;
    logic        ez;
    logic [63:0] held;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          bad;

    vecs.push_back(mk(4'd0,  32'd20, 32'd5, 64'd21, 1'b0));
    vecs.push_back(mk(4'd1,  32'd20, 32'd5, 64'd4, 1'b0));
    vecs.push_back(mk(4'd2,  32'd20, 32'd5, 64'h0000_0000_FFFF_FFEB, 1'b0));
    vecs.push_back(mk(4'd3,  32'd20, 32'd5, 64'd25, 1'b0));
    vecs.push_back(mk(4'd4,  32'd20, 32'd5, 64'd15, 1'b0));
    vecs.push_back(mk(4'd5,  32'd20, 32'd5, 64'h0000_0000_FFFF_FFEC, 1'b0));
    vecs.push_back(mk(4'd6,  32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0));
    vecs.push_back(mk(4'd7,  32'hFFFF_FFEC, 32'd6, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0));
    vecs.push_back(mk(4'd7,  32'd20, 32'd0, 64'h0000_0014_FFFF_FFFF, 1'b1));
    vecs.push_back(mk(4'd7,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0));
    vecs.push_back(mk(4'd6,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0));
    vecs.push_back(mk(4'd8,  32'hB2, 32'd2, 64'h2C8, 1'b0));
    vecs.push_back(mk(4'd9,  32'hB2, 32'd2, 64'h2C, 1'b0));
    vecs.push_back(mk(4'd10, 32'hB2, 32'd2, 64'h2C, 1'b0));
    vecs.push_back(mk(4'd10, 32'h8000_0000, 32'd4, 64'h0000_0000_F800_0000, 1'b0));
    vecs.push_back(mk(4'd11, 32'h8000_0001, 32'd1, 64'h3, 1'b0));
    vecs.push_back(mk(4'd12, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000, 1'b0));
    vecs.push_back(mk(4'd11, 32'h1234_5678, 32'd0, 64'h1234_5678, 1'b0));
    vecs.push_back(mk(4'd8,  32'd1, 32'h21, 64'd2, 1'b0));
    vecs.push_back(mk(4'd13, 32'd20, 32'd5, 64'd0, 1'b0));

    // Reset state
    tick(); tick();
    clear = 1'b0;
    check("reset req_ready", req_ready, 1);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset ALU_result", ALU_result, 0);
    check("reset div_by_zero", div_by_zero, 0);

    foreach (vecs[i]) do_op($sformatf("vec%0d op%0d", i, vecs[i].op),
                            vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz);

    // MUL with a stalled consumer; stray requests must be ignored.
    rsp_ready = 1'b0;
    issue(4'd6, 32'hFFFF_FFF9, 32'd6);
    req_valid = 1'b1; opcode = 4'd3; input_a = 32'd1; input_b = 32'd1;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (req_ready || rsp_valid) bad++;
      tick();
    end
    check("mul busy cycles 1-32 with ready/valid high", 64'(bad), 0);
    check("mul rsp_valid at cycle 33", rsp_valid, 1);
    check("mul req_ready at cycle 33", req_ready, 0);
    check("mul stall result", ALU_result, 64'hFFFF_FFFF_FFFF_FFD6);
    held = ALU_result;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!rsp_valid || req_ready || ALU_result !== held) bad++;
    end
    check("stalled response changed", 64'(bad), 0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("req_ready after handshake", req_ready, 1);
    check("rsp_valid after handshake", rsp_valid, 0);

    // clear in the middle of a DIV
    issue(4'd7, 32'hFFFF_FFEC, 32'd6);
    for (int k = 0; k < 14; k++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear mid-div req_ready", req_ready, 1);
    check("clear mid-div rsp_valid", rsp_valid, 0);
    check("clear mid-div ALU_result", ALU_result, 0);
    do_op("add after clear", 4'd3, 32'd1, 32'd1, 64'd2, 1'b0);

    // Randomised operations against the model
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(0, 40));
        2: rb = -32'($urandom_range(1, 40));
        default: ;
      endcase
      model(rop, ra, rb, er, ez);
      do_op($sformatf("rand%0d op%0d a=%0h b=%0h", n, rop, ra, rb), rop, ra, rb, er, ez);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
